// File: rtl/color_pkg.sv
// Shared colour types used across the raster pipeline.
// Provides color12_t: packed {r,g,b} with 4 bits per channel.
package color_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } color12_t;

endpackage

// File: rtl/math_pkg.sv
// Shared fixed-point types used across the raster pipeline.
// Provides q16_16_t: signed 32-bit value with 16 fractional bits.
package math_pkg;

    typedef logic signed [31:0] q16_16_t;

endpackage

// File: rtl/raster_pkg.sv
// Raster pipeline constants, bundle types and weight saturation helper.
// Holds screen/subpixel geometry, weight formats and per-vertex attributes.
package raster_pkg;

    import color_pkg::*;
    import math_pkg::*;

    localparam int WIDTH           = 320;
    localparam int HEIGHT          = 240;
    localparam int SUBPIXEL_BITS   = 4;
    localparam int DENOM_INV_BITS  = 36;
    localparam int DENOM_INV_FBITS = 35;
    localparam int WEIGHT_FBITS    = 16;

    localparam int X_W          = $clog2(WIDTH);
    localparam int Y_W          = $clog2(HEIGHT);
    localparam int COORD_W      = 16 + SUBPIXEL_BITS;
    localparam int DELTA_W      = COORD_W + 1;
    localparam int CROSS_W      = DELTA_W + COORD_W + 1;
    localparam int PROD_W       = CROSS_W + DENOM_INV_BITS;
    localparam int WEIGHT_W     = WEIGHT_FBITS + 2;
    localparam int WEIGHT_SHIFT = DENOM_INV_FBITS - WEIGHT_FBITS;

    localparam int PIXEL_CENTER_OFFSET = 1 << (SUBPIXEL_BITS - 1);

    typedef logic signed [WEIGHT_W-1:0] bary_weight_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        color12_t       color;
        q16_16_t        depth;
    } fragment_t;

    typedef struct packed {
        color12_t c0;
        color12_t c1;
        color12_t c2;
        q16_16_t  z0;
        q16_16_t  z1;
        q16_16_t  z2;
    } vtx_attr_t;

    localparam logic signed [PROD_W-1:0] WEIGHT_MAX =
        PROD_W'((1 << (WEIGHT_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] WEIGHT_MIN =
        PROD_W'(-(1 << (WEIGHT_W - 1)));

    // Rescale cross*denom_inv to weight format (floor), then saturate.
    function automatic bary_weight_t sat_weight(
        input logic signed [PROD_W-1:0] p
    );
        logic signed [PROD_W-1:0] s;
        s = p >>> WEIGHT_SHIFT;
        if (s > WEIGHT_MAX)
            return WEIGHT_MAX[WEIGHT_W-1:0];
        else if (s < WEIGHT_MIN)
            return WEIGHT_MIN[WEIGHT_W-1:0];
        else
            return s[WEIGHT_W-1:0];
    endfunction

endpackage

// File: rtl/bary_interp_channel.sv
// Weighted barycentric sum of one vertex attribute, optional round/clamp.
// Ports: w0/u/v weights, a0/a1/a2 vertex attribute values, result.
module bary_interp_channel
    import raster_pkg::*;
#(
    parameter int AW          = 4,
    parameter bit ATTR_SIGNED = 1'b0,
    parameter bit ROUND       = 1'b1,
    parameter bit CLAMP       = 1'b1,
    parameter int OW          = 4
) (
    input  bary_weight_t    w0,
    input  bary_weight_t    u,
    input  bary_weight_t    v,
    input  logic [AW-1:0]   a0,
    input  logic [AW-1:0]   a1,
    input  logic [AW-1:0]   a2,
    output logic [OW-1:0]   result
);

    localparam int SW = WEIGHT_W + AW + 3;

    localparam logic signed [SW-1:0] RND =
        SW'(ROUND ? (1 << (WEIGHT_FBITS - 1)) : 0);
    localparam logic signed [SW-1:0] MAXV =
        SW'((longint'(1) << OW) - 1);

    function automatic logic signed [SW-1:0] ext(input logic [AW-1:0] a);
        if (ATTR_SIGNED)
            return SW'(signed'(a));
        else
            return SW'({1'b0, a});
    endfunction

    logic signed [SW-1:0] acc;
    logic signed [SW-1:0] shifted;

    assign acc = SW'(w0) * ext(a0)
               + SW'(u)  * ext(a1)
               + SW'(v)  * ext(a2)
               + RND;

    assign shifted = acc >>> WEIGHT_FBITS;

    always_comb begin
        result = shifted[OW-1:0];
        if (CLAMP) begin
            if (shifted < 0)
                result = '0;
            else if (shifted > MAXV)
                result = '1;
        end
    end

endmodule

// File: rtl/barycentric_eval.sv
// Per-pixel barycentric test and colour/depth interpolation, 4 stages.
// Ports: in_* pixel + triangle setup (valid/ready), out_* fragment
// (valid/ready), busy. Optional RASTER_FRAG_STATS_EN adds stats_clear,
// frag_accepted_cnt and frag_rejected_cnt.
module barycentric_eval
    import color_pkg::*;
    import math_pkg::*;
    import raster_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [X_W-1:0]                   in_x,
    input  logic [Y_W-1:0]                   in_y,
    input  logic signed [COORD_W-1:0]        in_v0x,
    input  logic signed [COORD_W-1:0]        in_v0y,
    input  logic signed [COORD_W-1:0]        in_e0x,
    input  logic signed [COORD_W-1:0]        in_e0y,
    input  logic signed [COORD_W-1:0]        in_e1x,
    input  logic signed [COORD_W-1:0]        in_e1y,
    input  logic signed [DENOM_INV_BITS-1:0] in_denom_inv,
    input  color12_t                         in_v0_color,
    input  color12_t                         in_v1_color,
    input  color12_t                         in_v2_color,
    input  q16_16_t                          in_v0_depth,
    input  q16_16_t                          in_v1_depth,
    input  q16_16_t                          in_v2_depth,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [X_W-1:0]                   out_x,
    output logic [Y_W-1:0]                   out_y,
    output color12_t                         out_color,
    output q16_16_t                          out_depth,
    output logic                             out_valid,
    input  logic                             out_ready,
`ifdef RASTER_FRAG_STATS_EN
    input  logic                             stats_clear,
    output logic [31:0]                      frag_accepted_cnt,
    output logic [31:0]                      frag_rejected_cnt,
`endif
    output logic                             busy
);

    localparam int WIDE_W = WEIGHT_W + 2;
    localparam logic signed [WIDE_W-1:0] W_ONE = WIDE_W'(1 << WEIGHT_FBITS);

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // S1: pixel centre relative to v0
    logic                             s1_valid;
    logic [X_W-1:0]                   s1_x;
    logic [Y_W-1:0]                   s1_y;
    logic signed [DELTA_W-1:0]        s1_dx, s1_dy;
    logic signed [COORD_W-1:0]        s1_e0x, s1_e0y, s1_e1x, s1_e1y;
    logic signed [DENOM_INV_BITS-1:0] s1_dinv;
    vtx_attr_t                        s1_attr;

    logic signed [DELTA_W-1:0] px, py;
    assign px = DELTA_W'({in_x, {SUBPIXEL_BITS{1'b0}}})
              + DELTA_W'(PIXEL_CENTER_OFFSET);
    assign py = DELTA_W'({in_y, {SUBPIXEL_BITS{1'b0}}})
              + DELTA_W'(PIXEL_CENTER_OFFSET);

    // S2: unnormalised weights (edge cross products)
    logic                             s2_valid;
    logic [X_W-1:0]                   s2_x;
    logic [Y_W-1:0]                   s2_y;
    logic signed [CROSS_W-1:0]        s2_cu, s2_cv;
    logic signed [DENOM_INV_BITS-1:0] s2_dinv;
    vtx_attr_t                        s2_attr;

    logic signed [CROSS_W-1:0] cu_next, cv_next;
    assign cu_next = CROSS_W'(s1_dx) * CROSS_W'(s1_e1y)
                   - CROSS_W'(s1_dy) * CROSS_W'(s1_e1x);
    assign cv_next = CROSS_W'(s1_e0x) * CROSS_W'(s1_dy)
                   - CROSS_W'(s1_e0y) * CROSS_W'(s1_dx);

    // S3: normalised weights and inside test
    logic           s3_valid;
    logic [X_W-1:0] s3_x;
    logic [Y_W-1:0] s3_y;
    bary_weight_t   s3_u, s3_v, s3_w0;
    logic           s3_inside;
    vtx_attr_t      s3_attr;

    logic signed [PROD_W-1:0] pu, pv;
    bary_weight_t             u_next, v_next;
    logic signed [WIDE_W-1:0] w0_wide;
    logic                     inside_next;

    assign pu      = PROD_W'(s2_cu) * PROD_W'(s2_dinv);
    assign pv      = PROD_W'(s2_cv) * PROD_W'(s2_dinv);
    assign u_next  = sat_weight(pu);
    assign v_next  = sat_weight(pv);
    assign w0_wide = W_ONE - WIDE_W'(u_next) - WIDE_W'(v_next);

    // Negative denom_inv flips cu/cv sign, so both windings pass here.
    assign inside_next = !u_next[WEIGHT_W-1]
                      && !v_next[WEIGHT_W-1]
                      && !w0_wide[WIDE_W-1];

    // S4: attribute interpolation into the output register
    color12_t  c_next;
    q16_16_t   z_next;
    fragment_t out_frag;

    bary_interp_channel #(.AW(4), .ATTR_SIGNED(1'b0), .ROUND(1'b1),
                          .CLAMP(1'b1), .OW(4)) u_r (
        .w0(s3_w0), .u(s3_u), .v(s3_v),
        .a0(s3_attr.c0.r), .a1(s3_attr.c1.r), .a2(s3_attr.c2.r),
        .result(c_next.r)
    );

    bary_interp_channel #(.AW(4), .ATTR_SIGNED(1'b0), .ROUND(1'b1),
                          .CLAMP(1'b1), .OW(4)) u_g (
        .w0(s3_w0), .u(s3_u), .v(s3_v),
        .a0(s3_attr.c0.g), .a1(s3_attr.c1.g), .a2(s3_attr.c2.g),
        .result(c_next.g)
    );

    bary_interp_channel #(.AW(4), .ATTR_SIGNED(1'b0), .ROUND(1'b1),
                          .CLAMP(1'b1), .OW(4)) u_b (
        .w0(s3_w0), .u(s3_u), .v(s3_v),
        .a0(s3_attr.c0.b), .a1(s3_attr.c1.b), .a2(s3_attr.c2.b),
        .result(c_next.b)
    );

    // Depth: floor shift, wraps to 32 bits, no rounding or clamping.
    bary_interp_channel #(.AW(32), .ATTR_SIGNED(1'b1), .ROUND(1'b0),
                          .CLAMP(1'b0), .OW(32)) u_z (
        .w0(s3_w0), .u(s3_u), .v(s3_v),
        .a0(s3_attr.z0), .a1(s3_attr.z1), .a2(s3_attr.z2),
        .result(z_next)
    );

    // Valids and output register carry reset; payload does not need it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_frag  <= '0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            s3_valid  <= s2_valid;
            out_valid <= s3_valid && s3_inside;
            out_frag  <= '{x: s3_x, y: s3_y, color: c_next, depth: z_next};
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s1_x      <= in_x;
            s1_y      <= in_y;
            s1_dx     <= px - DELTA_W'(in_v0x);
            s1_dy     <= py - DELTA_W'(in_v0y);
            s1_e0x    <= in_e0x;
            s1_e0y    <= in_e0y;
            s1_e1x    <= in_e1x;
            s1_e1y    <= in_e1y;
            s1_dinv   <= in_denom_inv;
            s1_attr   <= '{c0: in_v0_color, c1: in_v1_color,
                           c2: in_v2_color, z0: in_v0_depth,
                           z1: in_v1_depth, z2: in_v2_depth};

            s2_x      <= s1_x;
            s2_y      <= s1_y;
            s2_cu     <= cu_next;
            s2_cv     <= cv_next;
            s2_dinv   <= s1_dinv;
            s2_attr   <= s1_attr;

            s3_x      <= s2_x;
            s3_y      <= s2_y;
            s3_u      <= u_next;
            s3_v      <= v_next;
            // Only inside entries use w0, and those always fit the weight width.
            s3_w0     <= w0_wide[WEIGHT_W-1:0];
            s3_inside <= inside_next;
            s3_attr   <= s2_attr;
        end
    end

    assign out_x     = out_frag.x;
    assign out_y     = out_frag.y;
    assign out_color = out_frag.color;
    assign out_depth = out_frag.depth;

    assign busy = s1_valid | s2_valid | s3_valid | out_valid;

`ifdef RASTER_FRAG_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n || stats_clear) begin
            frag_accepted_cnt <= '0;
            frag_rejected_cnt <= '0;
        end else if (en && s3_valid) begin
            if (s3_inside) begin
                if (frag_accepted_cnt != '1)
                    frag_accepted_cnt <= frag_accepted_cnt + 32'd1;
            end else begin
                if (frag_rejected_cnt != '1)
                    frag_rejected_cnt <= frag_rejected_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
